// File: rtl/dt_engine_param_if.sv
`default_nettype none
// ============================================================================
// dt_engine_param_if : control handshake plus sti ROM / res RAM bus
// Revision: 1.0
// ============================================================================
interface dt_engine_param_if #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int STI_W  = 16,
  parameter int DIST_W = 8,
  parameter int STI_AW = $clog2(IMG_W * IMG_H / STI_W),
  parameter int RES_AW = $clog2(IMG_W * IMG_H)
);
  logic              start;
  logic              mode;
  logic              busy;
  logic              done;
  logic              sti_rd;
  logic [STI_AW-1:0] sti_addr;
  logic [STI_W-1:0]  sti_di;
  logic              res_wr;
  logic              res_rd;
  logic [RES_AW-1:0] res_addr;
  logic [DIST_W-1:0] res_do;
  logic [DIST_W-1:0] res_di;

  modport master (
    input  start, mode, sti_di, res_di,
    output busy, done, sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do
  );

  modport slave (
    output start, mode, sti_di, res_di,
    input  busy, done, sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do
  );
endinterface
`default_nettype wire

// File: rtl/dt_engine_param.sv
`default_nettype none
// ============================================================================
// dt_engine_param : two-pass chessboard / city-block distance-transform engine
// Revision: 1.0
// ============================================================================
module dt_engine_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int STI_W  = 16,
  parameter int DIST_W = 8,
  parameter int STI_AW = $clog2(IMG_W * IMG_H / STI_W),
  parameter int RES_AW = $clog2(IMG_W * IMG_H)
) (
  input wire logic          clk,
  input wire logic          reset,
  dt_engine_param_if.master bus
);
  localparam int                c_XW       = $clog2(IMG_W);
  localparam int                c_YW       = RES_AW - c_XW;
  localparam int                c_BW       = $clog2(STI_W);
  localparam int                c_DW1      = DIST_W + 1;
  localparam logic [RES_AW-1:0] c_LAST_PIX = RES_AW'(IMG_W * IMG_H - 1);
  localparam logic [RES_AW-1:0] c_ROW      = RES_AW'(IMG_W);
  localparam logic [c_XW-1:0]   c_X_MAX    = c_XW'(IMG_W - 1);
  localparam logic [c_YW-1:0]   c_Y_MAX    = c_YW'(IMG_H - 1);
  localparam logic [DIST_W-1:0] c_DMAX     = '1;

  localparam logic [3:0] c_S_IDLE    = 4'd0;
  localparam logic [3:0] c_S_INIT_RD = 4'd1;
  localparam logic [3:0] c_S_INIT_LD = 4'd2;
  localparam logic [3:0] c_S_INIT_WR = 4'd3;
  localparam logic [3:0] c_S_PX_RD   = 4'd4;
  localparam logic [3:0] c_S_PX_CHK  = 4'd5;
  localparam logic [3:0] c_S_NB      = 4'd6;
  localparam logic [3:0] c_S_NB_WAIT = 4'd7;
  localparam logic [3:0] c_S_PX_WR   = 4'd8;
  localparam logic [3:0] c_S_DONE    = 4'd9;

  logic [3:0]        r_state;
  logic [3:0]        w_state_nxt;
  logic              r_mode;
  logic              r_bwd;
  logic [RES_AW-1:0] r_pix;
  logic [STI_AW-1:0] r_waddr;
  logic [STI_W-1:0]  r_word;
  logic [c_BW-1:0]   r_bit;
  logic [DIST_W-1:0] r_self;
  logic [DIST_W-1:0] r_min;
  logic [2:0]        r_nb;

  logic              w_bit_last;
  logic [3:0]        w_px_next;
  logic              w_px_done;
  logic [c_XW-1:0]   w_x;
  logic [c_YW-1:0]   w_y;
  logic              w_h_back, w_h_fwd, w_vert;
  logic              w_left, w_right, w_up, w_down;
  logic              w_nb_end, w_nb_active, w_nb_inside, w_nb_fetch;
  logic [RES_AW-1:0] w_nb_addr;
  logic [c_DW1-1:0]  w_inc;
  logic [DIST_W-1:0] w_cand;
  logic [DIST_W-1:0] w_val;
  logic              w_wr_px;

  assign w_bit_last = (r_bit == c_BW'(STI_W - 1));
  assign w_px_next  = (r_bwd && r_pix == '0) ? c_S_DONE : c_S_PX_RD;
  assign w_px_done  = ((r_state == c_S_PX_CHK) && (bus.res_di == '0)) || (r_state == c_S_PX_WR);

  // Neighbour slots 0..3: W,NW,N,NE in the forward pass, mirrored to E,SE,S,SW backwards
  assign w_x         = r_pix[c_XW-1:0];
  assign w_y         = r_pix[RES_AW-1:c_XW];
  assign w_h_back    = (r_nb[1:0] == 2'd0) || (r_nb[1:0] == 2'd1);
  assign w_h_fwd     = (r_nb[1:0] == 2'd3);
  assign w_vert      = (r_nb[1:0] != 2'd0);
  assign w_left      = r_bwd ? w_h_fwd  : w_h_back;
  assign w_right     = r_bwd ? w_h_back : w_h_fwd;
  assign w_up        = !r_bwd && w_vert;
  assign w_down      = r_bwd && w_vert;
  assign w_nb_end    = r_nb[2];
  assign w_nb_active = !r_nb[0] || !r_mode;
  assign w_nb_inside = !(w_left  && w_x == '0)      && !(w_right && w_x == c_X_MAX) &&
                       !(w_up    && w_y == '0)      && !(w_down  && w_y == c_Y_MAX);
  assign w_nb_fetch  = w_nb_active && w_nb_inside;
  assign w_nb_addr   = r_pix + (w_down ? c_ROW : '0) - (w_up ? c_ROW : '0)
                     + (w_right ? RES_AW'(1) : '0) - (w_left ? RES_AW'(1) : '0);

  assign w_inc   = {1'b0, r_min} + c_DW1'(1);
  assign w_cand  = w_inc[DIST_W] ? c_DMAX : w_inc[DIST_W-1:0];
  assign w_val   = (r_bwd && r_self < w_cand) ? r_self : w_cand;
  assign w_wr_px = !r_bwd || (w_val != r_self);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= c_S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE, c_S_DONE: if (bus.start) w_state_nxt = c_S_INIT_RD;
      c_S_INIT_RD: w_state_nxt = c_S_INIT_LD;
      c_S_INIT_LD: w_state_nxt = c_S_INIT_WR;
      c_S_INIT_WR: if (w_bit_last) w_state_nxt = (r_pix == c_LAST_PIX) ? c_S_PX_RD : c_S_INIT_RD;
      c_S_PX_RD:   w_state_nxt = c_S_PX_CHK;
      c_S_PX_CHK:  w_state_nxt = (bus.res_di == '0) ? w_px_next : c_S_NB;
      c_S_NB: begin
        if (w_nb_end)        w_state_nxt = c_S_PX_WR;
        else if (w_nb_fetch) w_state_nxt = c_S_NB_WAIT;
      end
      c_S_NB_WAIT: w_state_nxt = c_S_NB;
      c_S_PX_WR:   w_state_nxt = w_px_next;
      default:     w_state_nxt = c_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mode  <= 1'b0;
      r_bwd   <= 1'b0;
      r_pix   <= '0;
      r_waddr <= '0;
      r_word  <= '0;
      r_bit   <= '0;
      r_self  <= '0;
      r_min   <= '0;
      r_nb    <= '0;
    end else begin
      case (r_state)
        c_S_IDLE, c_S_DONE: begin
          if (bus.start) begin
            r_mode  <= bus.mode;
            r_bwd   <= 1'b0;
            r_pix   <= '0;
            r_waddr <= '0;
          end
        end
        c_S_INIT_LD: begin
          r_word <= bus.sti_di;
          r_bit  <= '0;
        end
        c_S_INIT_WR: begin
          r_word <= r_word << 1;
          r_bit  <= r_bit + c_BW'(1);
          r_pix  <= r_pix + RES_AW'(1);
          if (w_bit_last) r_waddr <= r_waddr + STI_AW'(1);
        end
        c_S_PX_CHK: begin
          r_self <= bus.res_di;
          r_min  <= c_DMAX;
          r_nb   <= '0;
        end
        c_S_NB: begin
          // Skipped slots: out-of-image neighbours count as background (0)
          if (!w_nb_end && !w_nb_fetch) begin
            if (w_nb_active) r_min <= '0;
            r_nb <= r_nb + 3'd1;
          end
        end
        c_S_NB_WAIT: begin
          if (bus.res_di < r_min) r_min <= bus.res_di;
          r_nb <= r_nb + 3'd1;
        end
        default: ;
      endcase

      if (w_px_done) begin
        if (!r_bwd) begin
          if (r_pix == c_LAST_PIX) r_bwd <= 1'b1;
          else                     r_pix <= r_pix + RES_AW'(1);
        end else begin
          r_pix <= r_pix - RES_AW'(1);
        end
      end
    end
  end

  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.sti_rd   = 1'b0;
    bus.sti_addr = '0;
    bus.res_wr   = 1'b0;
    bus.res_rd   = 1'b0;
    bus.res_addr = '0;
    bus.res_do   = '0;
    case (r_state)
      c_S_DONE: bus.done = 1'b1;
      c_S_INIT_RD: begin
        bus.busy     = 1'b1;
        bus.sti_rd   = 1'b1;
        bus.sti_addr = r_waddr;
      end
      c_S_INIT_WR: begin
        bus.busy     = 1'b1;
        bus.res_wr   = 1'b1;
        bus.res_addr = r_pix;
        bus.res_do   = DIST_W'(r_word[STI_W-1]);
      end
      c_S_PX_RD: begin
        bus.busy     = 1'b1;
        bus.res_rd   = 1'b1;
        bus.res_addr = r_pix;
      end
      c_S_NB: begin
        bus.busy = 1'b1;
        if (!w_nb_end && w_nb_fetch) begin
          bus.res_rd   = 1'b1;
          bus.res_addr = w_nb_addr;
        end
      end
      c_S_PX_WR: begin
        bus.busy     = 1'b1;
        bus.res_wr   = w_wr_px;
        bus.res_addr = r_pix;
        bus.res_do   = w_val;
      end
      c_S_INIT_LD, c_S_PX_CHK, c_S_NB_WAIT: bus.busy = 1'b1;
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_dt_engine_param.sv
`default_nettype none
// ============================================================================
// tb_dt_engine_param : directed and random images against a geometric distance model
// Revision: 1.0
// ============================================================================
module tb_dt_engine_param;
  localparam int IMG_W  = 16;
  localparam int IMG_H  = 16;
  localparam int STI_W  = 8;
  localparam int DIST_W = 3;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWORD  = NPIX / STI_W;
  localparam int STI_AW = $clog2(NWORD);
  localparam int RES_AW = $clog2(NPIX);
  localparam int DMAX   = (1 << DIST_W) - 1;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic reset;

  dt_engine_param_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .STI_W(STI_W), .DIST_W(DIST_W),
                       .STI_AW(STI_AW), .RES_AW(RES_AW)) bus ();

  dt_engine_param #(.IMG_W(IMG_W), .IMG_H(IMG_H), .STI_W(STI_W), .DIST_W(DIST_W),
                    .STI_AW(STI_AW), .RES_AW(RES_AW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [STI_W-1:0]  rom [NWORD];
  logic [DIST_W-1:0] ram [NPIX];
  bit                img [NPIX];
  int                exp_q[$];
  int                vectors = 0;
  int                errors  = 0;

  // Memories: registered read, data valid the cycle after the strobe
  always @(posedge clk) begin
    if (bus.sti_rd) bus.sti_di <= rom[bus.sti_addr];
    if (bus.res_rd) bus.res_di <= ram[bus.res_addr];
    if (bus.res_wr) ram[bus.res_addr] <= bus.res_do;
  end

  task automatic check(string name, int idx, int act, int expv);
    vectors++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, expv);
    end
  endtask

  // Distance to the nearest background pixel, the outside of the image counting as background
  function automatic int golden(int p, bit m);
    int x, y, d, dx, dy, dd;
    if (!img[p]) return 0;
    x = p % IMG_W;
    y = p / IMG_W;
    d = x + 1;
    if (y + 1 < d)     d = y + 1;
    if (IMG_W - x < d) d = IMG_W - x;
    if (IMG_H - y < d) d = IMG_H - y;
    for (int q = 0; q < NPIX; q++) begin
      if (!img[q]) begin
        dx = (q % IMG_W) - x; if (dx < 0) dx = -dx;
        dy = (q / IMG_W) - y; if (dy < 0) dy = -dy;
        dd = m ? dx + dy : ((dx > dy) ? dx : dy);
        if (dd < d) d = dd;
      end
    end
    return (d > DMAX) ? DMAX : d;
  endfunction

  task automatic set_image(int kind);
    for (int p = 0; p < NPIX; p++) begin
      int x = p % IMG_W;
      int y = p / IMG_W;
      case (kind)
        1:       img[p] = (x == 3 && y == 3);
        2:       img[p] = (x >= 1 && x <= 5 && y >= 1 && y <= 5);
        3:       img[p] = 1'b1;
        4:       img[p] = ($urandom_range(1, 0) == 1);
        5:       img[p] = ($urandom_range(9, 0) < 8);
        default: img[p] = 1'b0;
      endcase
    end
    for (int w = 0; w < NWORD; w++)
      for (int k = 0; k < STI_W; k++)
        rom[w][STI_W-1-k] = img[w*STI_W + k];
  endtask

  task automatic push_expected(bit m);
    for (int p = 0; p < NPIX; p++) exp_q.push_back(golden(p, m));
  endtask

  task automatic start_run(bit m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = ~m;
    check("start_busy", 0, bus.busy, 1);
    check("start_done", 0, bus.done, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("done_timeout", n, 0, 1);
    check("done_busy", 0, bus.busy, 0);
  endtask

  task automatic run(int kind, bit m);
    set_image(kind);
    push_expected(m);
    start_run(m);
    wait_done();
  endtask

  task automatic check_idle(int tag);
    check("idle_busy",   tag, bus.busy,     0);
    check("idle_done",   tag, bus.done,     0);
    check("idle_sti_rd", tag, bus.sti_rd,   0);
    check("idle_res_wr", tag, bus.res_wr,   0);
    check("idle_res_rd", tag, bus.res_rd,   0);
    check("idle_sti_a",  tag, bus.sti_addr, 0);
    check("idle_res_a",  tag, bus.res_addr, 0);
    check("idle_res_do", tag, bus.res_do,   0);
  endtask

  task automatic monitor();
    bit pd = 1'b0;
    bit pb = 1'b0;
    int viol = 0;
    int bad;
    int sti_cnt [NWORD];
    forever begin
      @(negedge clk);
      if ((bus.res_wr && bus.res_rd) || (!bus.busy && (bus.sti_rd || bus.res_wr || bus.res_rd)))
        viol++;
      if (bus.busy && !pb)
        for (int w = 0; w < NWORD; w++) sti_cnt[w] = 0;
      if (bus.sti_rd) sti_cnt[int'(bus.sti_addr)]++;
      if (bus.done && !pd) begin
        bad = 0;
        for (int w = 0; w < NWORD; w++) if (sti_cnt[w] != 1) bad++;
        check("sti_cover", 0, bad, 0);
        check("protocol", 0, viol, 0);
        if (exp_q.size() < NPIX) check("sb_underflow", 0, exp_q.size(), NPIX);
        else for (int p = 0; p < NPIX; p++) check("res", p, int'(ram[p]), exp_q.pop_front());
      end
      pd = bus.done;
      pb = bus.busy;
    end
  endtask

  initial begin
    int n;
    int hits;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    reset     = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_idle(0);

    run(1, 1'b0);
    run(2, 1'b0);
    run(2, 1'b1);
    run(3, 1'b0);

    // Start pulse during the forward pass must be ignored
    set_image(4);
    push_expected(1'b0);
    start_run(1'b0);
    n = 0;
    while (!bus.res_rd && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("fwd_seen", 0, bus.res_rd, 1);
    bus.start = 1'b1;
    bus.mode  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ignored_busy", 0, bus.busy, 1);
    check("ignored_done", 0, bus.done, 0);
    wait_done();

    run(5, 1'b1);

    // Abort in the backward pass: the second self-read of the last pixel opens it
    set_image(3);
    start_run(1'b1);
    hits = 0;
    n    = 0;
    while (hits < 2 && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (bus.res_rd && int'(bus.res_addr) == NPIX - 1) hits++;
    end
    check("bwd_seen", 0, hits, 2);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_idle(1);

    run(3, 1'b1);
    run(0, 1'b1);
    run(4, 1'b0);
    run(5, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_leftover", 0, exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
